// File: rtl/cmp_stats8b_if.sv
// cmp_stats8b_if
// Groups the sample stream, the stats clear, the report handshake and the
// report payload of cmp_stats8b into one bundle. The upstream and the
// report consumer sit on the master side; the stats stage uses the slave side.
//   clear                      stats clear / abort window
//   in_valid, in_ready         sample handshake
//   A, B                       operands as fed to the comparator
//   A_greater_B/equal/less     comparator result flags
//   report_valid, report_ready window report handshake
//   gt_cnt, eq_cnt, lt_cnt     outcome counts of the window
//   max_val                    largest winning operand of the window
//   flag_err                   sticky non-one-hot flag indication
interface cmp_stats8b_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             A_greater_B;
  logic             A_equal_B;
  logic             A_less_B;
  logic             report_valid;
  logic             report_ready;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;
  logic [WIDTH-1:0] max_val;
  logic             flag_err;

  modport master (
    output clear, in_valid, A, B, A_greater_B, A_equal_B, A_less_B, report_ready,
    input  in_ready, report_valid, gt_cnt, eq_cnt, lt_cnt, max_val, flag_err
  );

  modport slave (
    input  clear, in_valid, A, B, A_greater_B, A_equal_B, A_less_B, report_ready,
    output in_ready, report_valid, gt_cnt, eq_cnt, lt_cnt, max_val, flag_err
  );
endinterface

// File: rtl/cmp_stats8b.sv
// cmp_stats8b
// Windowed statistics stage behind an 8-bit magnitude comparator. Counts
// greater/equal/less outcomes over WIN accepted samples, tracks the largest
// winning operand, and then holds a report until the consumer takes it.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cmp_stats8b_if slave side (sample stream, clear, report handshake)
// All outputs come from registers or from the state register alone.
module cmp_stats8b #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8,
  parameter int WIN   = 16
) (
  input  logic          clk,
  input  logic          rst,
  cmp_stats8b_if.slave  bus
);

  typedef enum logic {ACCUM = 1'b0, REPORT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] gt_q, gt_d;
  logic [CNT_W-1:0] eq_q, eq_d;
  logic [CNT_W-1:0] lt_q, lt_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic             err_q, err_d;

  logic [2:0]       flags;
  logic             flags_ok;
  logic             wipe;
  logic [WIDTH-1:0] winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      smp_q   <= '0;
      gt_q    <= '0;
      eq_q    <= '0;
      lt_q    <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    smp_d    = smp_q;
    gt_d     = gt_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
    max_d    = max_q;
    err_d    = err_q;

    flags    = {bus.A_greater_B, bus.A_equal_B, bus.A_less_B};
    flags_ok = $onehot(flags);
    // A wins ties, so equal samples contribute A.
    winner   = (bus.A_greater_B || bus.A_equal_B) ? bus.A : bus.B;

    // clear aborts everything; a taken report starts the next window clean.
    wipe     = bus.clear || ((state_q == REPORT) && bus.report_ready);

    if (wipe) begin
      state_d = ACCUM;
      smp_d   = '0;
      gt_d    = '0;
      eq_d    = '0;
      lt_d    = '0;
      max_d   = '0;
      err_d   = 1'b0;
    end else if ((state_q == ACCUM) && bus.in_valid) begin
      // Malformed samples still consume a window slot.
      smp_d = smp_q + CNT_W'(1);
      if (flags_ok) begin
        if (bus.A_greater_B)    gt_d = gt_q + CNT_W'(1);
        else if (bus.A_equal_B) eq_d = eq_q + CNT_W'(1);
        else                    lt_d = lt_q + CNT_W'(1);
        if (winner > max_q) max_d = winner;
      end else begin
        err_d = 1'b1;
      end
      if (smp_d == WIN_C) state_d = REPORT;
    end
  end

  assign bus.in_ready     = (state_q == ACCUM);
  assign bus.report_valid = (state_q == REPORT);
  assign bus.gt_cnt       = gt_q;
  assign bus.eq_cnt       = eq_q;
  assign bus.lt_cnt       = lt_q;
  assign bus.max_val      = max_q;
  assign bus.flag_err     = err_q;

endmodule
